aes_decr_core: RTL and testbench
================================

Name: aes_decr_core

Overview:
- Iterative AES-128 decryption engine (FIPS-197 inverse cipher).
- Takes a 128-bit ciphertext and a 128-bit cipher key.
- Expands the key internally and runs the 10 inverse rounds, one round per clock.
- Presents the recovered plaintext on a held output register; used as the decrypt datapath beside the AES-128 encrypt core.

Parameters:
- DATA_WIDTH, 8, width of one state byte. Only 8 is supported; any other value is illegal.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- ip_data  input  128  ciphertext block. Byte 0 = [127:120]; state is column-major, so byte k goes to row k%4, column k/4.
- ip_key  input  128  AES-128 cipher key, same byte ordering.
- decr_data_out  output  128  decrypted plaintext, same byte ordering, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - decr_data_out = 0.
  - FSM = IDLE.
  - Captured data/key registers and all 11 round-key registers = 0.
  - Release is synchronous to clk.
- No handshake. The block samples ip_data/ip_key continuously.
- FSM states: IDLE, KEYEXP, ROUND, DONE.
- IDLE: on the next edge after reset release, capture ip_data/ip_key into cap_data/cap_key, set rk[0]=cap_key, go to KEYEXP with counter=1.
- KEYEXP, counter i = 1..10, one round key per edge: rk[i] = standard AES-128 expansion of rk[i-1]:
  - RotWord, then SubWord (forward S-box), then XOR Rcon[i].
  - Rcon = 01,02,04,08,10,20,40,80,1B,36 in the top byte.
  - After rk[10], go to ROUND.
- ROUND, first edge: state = cap_data XOR rk[10].
- ROUND, next 9 edges, for r = 9 down to 1: state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])).
- ROUND, final (10th) edge: decr_data_out = InvSubBytes(InvShiftRows(state)) XOR rk[0]; go to DONE.
- Latency: decr_data_out is updated on the 21st rising edge after the capture edge (10 key-expansion + 11 round edges).
- InvShiftRows: row n rotates right by n byte positions.
- InvMixColumns: matrix [0E 0B 0D 09] circulant over GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
- S-box and inverse S-box are combinational functions inside the module (GF(2^8) multiplicative inverse plus affine / inverse affine transform). No external memories.
- DONE: decr_data_out holds. If ip_data != cap_data or ip_key != cap_key, recapture both on that edge and go to KEYEXP. Otherwise stay in DONE.
- Input change mid-operation (KEYEXP or ROUND): abort, recapture both inputs on that edge, restart KEYEXP with counter=1. decr_data_out keeps its previous value; no partial result is ever written.
- Unknown/X inputs are treated as a change; no special handling.
- Reset asserted mid-operation: immediate return to the reset state above.
- No X propagation to decr_data_out after reset.

Test Plan:
- Reset: hold rst=0 for 3 cycles with any inputs -> decr_data_out=0. Release -> stays 0 for 20 edges after capture.
- FIPS-197 C.1: ip_key=000102030405060708090a0b0c0d0e0f, ip_data=69c4e0d86a7b0430d8cdb78070b4c55a -> decr_data_out=00112233445566778899aabbccddeeff exactly 21 edges after capture, then held.
- FIPS-197 App. B: ip_key=2b7e151628aed2a6abf7158809cf4f3c, ip_data=3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- Mid-operation change: apply the App. B vector, switch to the C.1 vector 10 ns later -> App. B result never appears; 00112233445566778899aabbccddeeff appears 21 edges after the switch.
- Reset mid-round: assert rst during ROUND -> output 0 immediately. Release with the C.1 vector -> correct result after 21 edges.
- Compare against a reference model: random key/ciphertext pairs from an AES-128 model, applied back-to-back after each DONE -> every output matches.

Source files
------------

// File: rtl/aes_decr_core.sv
// Iterative AES-128 inverse cipher.
// The key schedule is expanded into eleven round-key registers, one key per clock.
// The ten inverse rounds then run one per clock.
// The plaintext register is written only on a completed decryption, so an aborted
// run never disturbs the value held on decr_data_out.
module aes_decr_core #(
   parameter int DATA_WIDTH = 8   // state byte width; only 8 is meaningful for AES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] ip_data,
   input  logic [127:0] ip_key,
   output logic [127:0] decr_data_out
);

   typedef logic [DATA_WIDTH-1:0] byte_t;
   typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;

   // ---------------------------------------------------------------- GF(2^8) helpers
   function automatic byte_t xtime(input byte_t a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic byte_t gf_mul(input byte_t a, input byte_t b);
      byte_t p;
      byte_t x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse (and maps 0 to 0, as AES requires)
   function automatic byte_t gf_inv(input byte_t a);
      byte_t y;
      byte_t r;
      y = gf_mul(a, a);
      r = y;
      for (int i = 0; i < 6; i++) begin
         y = gf_mul(y, y);
         r = gf_mul(r, y);
      end
      return r;
   endfunction

   function automatic byte_t rotl8(input byte_t a, input int n);
      logic [15:0] t;
      t = {a, a} << n;
      return t[15:8];
   endfunction

   function automatic byte_t sbox(input byte_t a);
      byte_t b;
      b = gf_inv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic byte_t inv_sbox(input byte_t a);
      return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   // ---------------------------------------------------------------- state transforms
   // Byte k sits at [127-8k -: 8], row k%4, column k/4; row r rotates right by r.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      int           src;
      o = '0;
      for (int k = 0; k < 16; k++) begin
         src = 4 * (((k / 4) - (k % 4) + 4) % 4) + (k % 4);
         o[127-8*k -: 8] = s[127-8*src -: 8];
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      byte_t a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   // ---------------------------------------------------------------- key schedule
   function automatic byte_t rcon(input logic [3:0] i);
      byte_t r;
      case (i)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [127:0] expand_key(input logic [127:0] prev, input byte_t rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {prev[23:0], prev[31:24]};
      t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
      w0 = prev[127:96] ^ t;
      w1 = prev[95:64]  ^ w0;
      w2 = prev[63:32]  ^ w1;
      w3 = prev[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // ---------------------------------------------------------------- registers
   state_e       state_q;
   logic [3:0]   cnt_q;
   logic [127:0] cap_data_q;
   logic [127:0] cap_key_q;
   logic [127:0] rk_q [0:10];
   logic [127:0] st_q;
   logic [127:0] out_q;

   logic         load_d;
   logic [127:0] rk_next_d;
   logic [127:0] isb_w;
   logic [127:0] round_d;
   logic [127:0] final_d;

   // Next round key, next round state, final plaintext and the recapture decision
   always_comb begin
      load_d    = (state_q == IDLE) || (ip_data != cap_data_q) || (ip_key != cap_key_q);
      rk_next_d = expand_key(rk_q[cnt_q - 4'd1], rcon(cnt_q));
      isb_w     = inv_sub_bytes(inv_shift_rows(st_q));
      round_d   = inv_mix_columns(isb_w ^ rk_q[cnt_q]);
      final_d   = isb_w ^ rk_q[0];
   end

   // Control FSM with the key/state datapath; counter runs 1..10 in KEYEXP, 10..0 in ROUND
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cap_data_q <= '0;
         cap_key_q  <= '0;
         st_q       <= '0;
         out_q      <= '0;
         for (int i = 0; i < 11; i++) rk_q[i] <= '0;
      end else if (load_d) begin
         cap_data_q <= ip_data;
         cap_key_q  <= ip_key;
         rk_q[0]    <= ip_key;
         cnt_q      <= 4'd1;
         state_q    <= KEYEXP;
      end else begin
         case (state_q)
            KEYEXP: begin
               rk_q[cnt_q] <= rk_next_d;
               if (cnt_q == 4'd10) begin
                  state_q <= ROUND;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            ROUND: begin
               if (cnt_q == 4'd10) begin
                  st_q  <= cap_data_q ^ rk_q[10];
                  cnt_q <= cnt_q - 4'd1;
               end else if (cnt_q != 4'd0) begin
                  st_q  <= round_d;
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  out_q   <= final_d;
                  state_q <= DONE;
               end
            end
            default: begin
               state_q <= state_q;
            end
         endcase
      end
   end

   assign decr_data_out = out_q;

endmodule

// File: tb/tb_aes_decr_core.sv
// Bench for aes_decr_core: FIPS-197 vectors, abort/restart, reset behaviour and
// random blocks produced by a table-driven AES-128 encryption model.
module tb_aes_decr_core;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [127:0] ip_data = '0;
   logic [127:0] ip_key  = '0;
   logic [127:0] decr_data_out;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [7:0]   sb [256];
   logic [127:0] exp_out = '0;
   logic [127:0] expv;

   aes_decr_core #(.DATA_WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .ip_data      (ip_data),
      .ip_key       (ip_key),
      .decr_data_out(decr_data_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- reference model
   function automatic logic [7:0] rl8(input logic [7:0] a, input int n);
      logic [15:0] t;
      t = {a, a} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box built by walking powers of the generator 3 and its inverse together
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [31:0]  tw;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tw = w[i-1];
         if (i % 4 == 0) begin
            tw = {tw[23:0], tw[31:24]};
            tw = {sb[tw[31:24]], sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ tw;
      end
      for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8];
      for (int r = 0; r <= 10; r++) begin
         if (r > 0) begin
            for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
            for (int c = 0; c < 4; c++)
               for (int j = 0; j < 4; j++) s[4*c+j] = t[4*((c+j)%4)+j];
            if (r < 10) begin
               for (int c = 0; c < 4; c++) begin
                  a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                  s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                  s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                  s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                  s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
               end
            end
         end
         for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) s[4*c+j] = s[4*c+j] ^ w[4*r+c][31-8*j -: 8];
      end
      res = '0;
      for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
      return res;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------------------------------------------------------- stimulus helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [127:0] d, input logic [127:0] k);
      @(negedge clk);
      ip_data = d;
      ip_key  = k;
   endtask

   // ---------------------------------------------------------------- scenarios
   task automatic test_reset();
      rst     = 1'b0;
      ip_data = C1_CT;
      ip_key  = C1_KEY;
      repeat (3) begin
         step();
         n_checks++;
         if (decr_data_out !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_hold got %h want %h", decr_data_out, 128'h0);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      step();
      for (int e = 1; e <= 21; e++) begin
         step();
         expv = (e == 21) ? C1_PT : 128'h0;
         n_checks++;
         if (decr_data_out !== expv) begin
            n_fail++;
            $display("FAIL reset_release_e%0d got %h want %h", e, decr_data_out, expv);
         end
      end
      exp_out = C1_PT;
   endtask

   task automatic test_vector(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt);
      apply(ct, key);
      step();
      for (int e = 1; e <= 26; e++) begin
         step();
         expv = (e >= 21) ? pt : exp_out;
         n_checks++;
         if (decr_data_out !== expv) begin
            n_fail++;
            $display("FAIL vector_e%0d got %h want %h", e, decr_data_out, expv);
         end
      end
      exp_out = pt;
   endtask

   task automatic test_mid_change();
      logic [127:0] k, p, c;
      k = rnd128();
      p = rnd128();
      c = aes_enc(p, k);
      test_vector(c, k, p);
      apply(B_CT, B_KEY);
      step();
      apply(C1_CT, C1_KEY);
      step();
      for (int e = 1; e <= 24; e++) begin
         step();
         expv = (e >= 21) ? C1_PT : exp_out;
         n_checks++;
         if (decr_data_out !== expv) begin
            n_fail++;
            $display("FAIL mid_change_e%0d got %h want %h", e, decr_data_out, expv);
         end
      end
      exp_out = C1_PT;
   endtask

   task automatic test_reset_mid_round();
      apply(B_CT, B_KEY);
      step();
      repeat (14) step();
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (decr_data_out !== 128'h0) begin
         n_fail++;
         $display("FAIL reset_mid_round got %h want %h", decr_data_out, 128'h0);
      end
      apply(C1_CT, C1_KEY);
      step();
      n_checks++;
      if (decr_data_out !== 128'h0) begin
         n_fail++;
         $display("FAIL reset_mid_round_hold got %h want %h", decr_data_out, 128'h0);
      end
      @(negedge clk);
      rst = 1'b1;
      step();
      for (int e = 1; e <= 21; e++) begin
         step();
         expv = (e == 21) ? C1_PT : 128'h0;
         n_checks++;
         if (decr_data_out !== expv) begin
            n_fail++;
            $display("FAIL reset_mid_release_e%0d got %h want %h", e, decr_data_out, expv);
         end
      end
      exp_out = C1_PT;
   endtask

   task automatic test_back_to_back();
      logic [127:0] k, p, c;
      n_checks++;
      if (aes_enc(C1_PT, C1_KEY) !== C1_CT) begin
         n_fail++;
         $display("FAIL model_c1 got %h want %h", aes_enc(C1_PT, C1_KEY), C1_CT);
      end
      for (int n = 0; n < 8; n++) begin
         k = rnd128();
         p = rnd128();
         c = aes_enc(p, k);
         apply(c, k);
         step();
         for (int e = 1; e <= 21; e++) begin
            step();
            expv = (e == 21) ? p : exp_out;
            n_checks++;
            if (decr_data_out !== expv) begin
               n_fail++;
               $display("FAIL b2b%0d_e%0d got %h want %h", n, e, decr_data_out, expv);
            end
         end
         exp_out = p;
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_vector(B_CT, B_KEY, B_PT);
      test_vector(C1_CT, C1_KEY, C1_PT);
      test_mid_change();
      test_reset_mid_round();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
